// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-look-ahead adder.
// Holds the FSM state encoding, the slice width and the nibble-count helper.
package cla_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

   function automatic int nib(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-look-ahead slice.
// All carries are formed directly from generate/propagate terms and cin.
module cla4_slice
   import cla_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W-1:0] w_p;
   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

   assign sum = w_p ^ w_c;

endmodule

// File: rtl/cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder wrapped in a valid/ready handshake.
// One CLA slice is reused per nibble, LSB first, with the carry registered between nibbles.
module cla_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIB_N = nib(WIDTH);
   localparam int IDX_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_N - 1);

   generate
      if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
         $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_ovf;
   logic               r_out_valid;

   logic [SLICE_W-1:0] w_a_nib;
   logic [SLICE_W-1:0] w_b_nib;
   logic [SLICE_W-1:0] w_s_sum;
   logic               w_s_cout;
   logic               w_last;

   assign w_a_nib = r_a[SLICE_W*r_idx +: SLICE_W];
   assign w_b_nib = r_b[SLICE_W*r_idx +: SLICE_W];
   assign w_last  = (r_idx == LAST_IDX);

   cla4_slice u_slice (
      .a    (w_a_nib),
      .b    (w_b_nib),
      .cin  (r_carry),
      .sum  (w_s_sum),
      .cout (w_s_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; in DONE only the output handshake is honoured
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) w_state_nxt = ST_ADD;
            else          w_state_nxt = ST_IDLE;
         end
         ST_ADD: begin
            if (w_last) w_state_nxt = ST_DONE;
            else        w_state_nxt = ST_ADD;
         end
         ST_DONE: begin
            if (out_ready) w_state_nxt = ST_IDLE;
            else           w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, per-nibble accumulation and result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            ST_ADD: begin
               r_sum[SLICE_W*r_idx +: SLICE_W] <= w_s_sum;
               r_carry <= w_s_cout;
               r_idx   <= r_idx + IDX_W'(1);
               if (w_last) begin
                  // Last nibble's top bit is the final sum MSB
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 (w_s_sum[SLICE_W-1] != r_a[WIDTH-1]);
                  r_out_valid <= 1'b1;
                  r_idx       <= '0;
               end
            end
            ST_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_carry;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder (WIDTH=16): directed vectors, backpressure,
// mid-operation reset and a back-to-back random run against an integer-arithmetic model.
module tb_cla_serial_adder;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a_s;
   logic [W-1:0]  b_s;
   logic          cin_s;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum_s;
   logic          cout_s;
   logic          ovf_s;

   int errors = 0;
   int checks = 0;

   cla_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_s),
      .b         (b_s),
      .cin       (cin_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum_s),
      .cout      (cout_s),
      .overflow  (ovf_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned and signed integer sums
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      int unsigned u;
      int          sx;
      int          sy;
      int          s;
      logic [31:0] uv;
      logic        ov;
      u  = int'(x) + int'(y) + int'(c);
      sx = $signed(x);
      sy = $signed(y);
      s  = sx + sy + int'(c);
      ov = (s > 32767) || (s < -32768);
      uv = u;
      return {ov, uv[W], uv[W-1:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present operands in IDLE, wait for out_valid; returns cycles from accept to result
   task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output int lat);
      int n;
      a_s      = x;
      b_s      = y;
      cin_s    = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a_s      = ~x;
      b_s      = ~y;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      lat = n + 1;
   endtask

   task automatic chk_model(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
      logic [W+1:0] r;
      r = model(x, y, c);
      chk({tag, "_sum"},  32'(sum_s),  32'(r[W-1:0]));
      chk({tag, "_cout"}, 32'(cout_s), 32'(r[W]));
      chk({tag, "_ovf"},  32'(ovf_s),  32'(r[W+1]));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready",  32'(in_ready),  32'd1);
   endtask

   initial begin
      int lat;
      logic [W-1:0] held_sum;
      logic         held_cout;
      logic         held_ovf;
      logic [W+1:0] q_exp[$];
      logic [W+1:0] e;
      int cyc;
      int n_acc;
      int n_out;
      int last_acc;
      logic acc;
      logic outh;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_s       = '0;
      b_s       = '0;
      cin_s     = 1'b0;
      #12;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum_s),     32'd0);
      chk("rst_cout",      32'(cout_s),    32'd0);
      chk("rst_ovf",       32'(ovf_s),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed vectors from the plan
      run_txn(16'h1234, 16'h4321, 1'b0, lat);
      chk("t1_latency", 32'(lat), 32'd5);
      chk("t1_sum",  32'(sum_s),  32'h5555);
      chk("t1_cout", 32'(cout_s), 32'd0);
      chk("t1_ovf",  32'(ovf_s),  32'd0);
      chk("t1_in_ready", 32'(in_ready), 32'd0);
      release_out();

      run_txn(16'hFFFF, 16'h0001, 1'b0, lat);
      chk("t2_sum",  32'(sum_s),  32'h0000);
      chk("t2_cout", 32'(cout_s), 32'd1);
      chk("t2_ovf",  32'(ovf_s),  32'd0);
      release_out();

      run_txn(16'h7FFF, 16'h0001, 1'b0, lat);
      chk("t3_sum",  32'(sum_s),  32'h8000);
      chk("t3_cout", 32'(cout_s), 32'd0);
      chk("t3_ovf",  32'(ovf_s),  32'd1);
      release_out();

      run_txn(16'h8000, 16'h8000, 1'b1, lat);
      chk("t4_sum",  32'(sum_s),  32'h0001);
      chk("t4_cout", 32'(cout_s), 32'd1);
      chk("t4_ovf",  32'(ovf_s),  32'd1);
      release_out();

      // Backpressure: hold 10 cycles while poking in_valid
      run_txn(16'hA5C3, 16'h3C5A, 1'b1, lat);
      chk_model("bp", 16'hA5C3, 16'h3C5A, 1'b1);
      held_sum  = sum_s;
      held_cout = cout_s;
      held_ovf  = ovf_s;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a_s      = 16'(i * 16'h1111);
         b_s      = 16'hFFFF;
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_sum",       32'(sum_s),     32'(held_sum));
         chk("bp_cout",      32'(cout_s),    32'(held_cout));
         chk("bp_ovf",       32'(ovf_s),     32'(held_ovf));
      end
      in_valid = 1'b0;
      release_out();
      tick();
      chk("bp_no_capture_valid", 32'(out_valid), 32'd0);
      chk("bp_no_capture_ready", 32'(in_ready),  32'd1);

      // Reset during second ADD cycle
      a_s      = 16'h1234;
      b_s      = 16'h4321;
      cin_s    = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum",       32'(sum_s),     32'd0);
      chk("mid_rst_cout",      32'(cout_s),    32'd0);
      chk("mid_rst_ovf",       32'(ovf_s),     32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NIB + 2; i++) begin
         tick();
         chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      run_txn(16'h00FF, 16'h0001, 1'b0, lat);
      chk("post_rst_latency", 32'(lat), 32'd5);
      chk("post_rst_sum",  32'(sum_s),  32'h0100);
      chk("post_rst_cout", 32'(cout_s), 32'd0);
      chk("post_rst_ovf",  32'(ovf_s),  32'd0);
      release_out();

      // Back-to-back random run with in_valid and out_ready held high
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a_s       = 16'($urandom);
      b_s       = 16'($urandom);
      cin_s     = 1'($urandom);
      cyc = 0; n_acc = 0; n_out = 0; last_acc = 0;
      while (n_out < 100 && cyc < 1000) begin
         acc  = in_ready && in_valid;
         outh = out_valid && out_ready;
         if (outh) begin
            if (q_exp.size() > 0) begin
               e = q_exp.pop_front();
               chk("b2b_sum",  32'(sum_s),  32'(e[W-1:0]));
               chk("b2b_cout", 32'(cout_s), 32'(e[W]));
               chk("b2b_ovf",  32'(ovf_s),  32'(e[W+1]));
            end else begin
               chk("b2b_unexpected_out", 32'd1, 32'd0);
            end
            n_out++;
         end
         if (acc) begin
            q_exp.push_back(model(a_s, b_s, cin_s));
            if (n_acc > 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            n_acc++;
         end
         tick();
         cyc++;
         if (acc) begin
            a_s   = 16'($urandom);
            b_s   = 16'($urandom);
            cin_s = 1'($urandom);
            if (n_acc == 100) in_valid = 1'b0;
         end
      end
      chk("b2b_out_count", 32'(n_out), 32'd100);
      chk("b2b_acc_count", 32'(n_acc), 32'd100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
